bcd_down_counter: RTL and testbench



---
 rtl/bcd_down_counter.sv | 97 +++++++++
 tb/tb_bcd_down_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter.sv
// Presettable two-digit BCD down counter (99..00) with one-shot / auto-reload
// modes and a single-cycle registered borrow pulse on the 01 -> 00 step.
module bcd_down_counter (
  input  logic       Clk,
  input  logic       MR,
  input  logic       LD,
  input  logic       EN,
  input  logic       MODE,
  input  logic [3:0] DH,
  input  logic [3:0] DL,
  output logic [3:0] QH,
  output logic [3:0] QL,
  output logic       BO,
  output logic       ZERO,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] pre_h, pre_l, pre_h_next, pre_l_next;
  logic [3:0] qh_next, ql_next;
  logic       bo_next;
  logic [3:0] dh_clamped, dl_clamped;

  // Out-of-range preset digits saturate at 9 so the count stays valid BCD.
  assign dh_clamped = (DH > 4'd9) ? 4'd9 : DH;
  assign dl_clamped = (DL > 4'd9) ? 4'd9 : DL;

  // State register: FSM state, count digits, preset register and borrow flag.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      state <= IDLE;
      QH    <= 4'd0;
      QL    <= 4'd0;
      pre_h <= 4'd0;
      pre_l <= 4'd0;
      BO    <= 1'b0;
    end else begin
      state <= state_next;
      QH    <= qh_next;
      QL    <= ql_next;
      pre_h <= pre_h_next;
      pre_l <= pre_l_next;
      BO    <= bo_next;
    end
  end

  // Next-state logic: load beats counting; counting only happens in RUN with EN.
  always_comb begin
    state_next = state;
    qh_next    = QH;
    ql_next    = QL;
    pre_h_next = pre_h;
    pre_l_next = pre_l;
    bo_next    = 1'b0;
    if (LD) begin
      pre_h_next = dh_clamped;
      pre_l_next = dl_clamped;
      qh_next    = dh_clamped;
      ql_next    = dl_clamped;
      state_next = ((dh_clamped != 4'd0) || (dl_clamped != 4'd0)) ? RUN : DONE;
    end else if ((state == RUN) && EN) begin
      if (ZERO) begin
        // Sitting at 00 after a terminal event: reload or stop, never borrow again.
        if (MODE) begin
          qh_next = pre_h;
          ql_next = pre_l;
        end else begin
          state_next = DONE;
        end
      end else begin
        if (QL != 4'd0) begin
          ql_next = QL - 4'd1;
        end else begin
          ql_next = 4'd9;
          qh_next = QH - 4'd1;
        end
        if ((QH == 4'd0) && (QL == 4'd1)) begin
          bo_next = 1'b1;
          if (!MODE) state_next = DONE;
        end
      end
    end
  end

  // Output decode.
  always_comb begin
    ZERO = (QH == 4'd0) && (QL == 4'd0);
    BUSY = (state == RUN);
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench for bcd_down_counter; each task covers one scenario.
module tb_bcd_down_counter;

  logic       Clk = 1'b0;
  logic       MR  = 1'b1;
  logic       LD  = 1'b0;
  logic       EN  = 1'b0;
  logic       MODE = 1'b0;
  logic [3:0] DH = 4'd0;
  logic [3:0] DL = 4'd0;
  logic [3:0] QH, QL;
  logic       BO, ZERO, BUSY;

  int checks   = 0;
  int failures = 0;

  bcd_down_counter dut (
    .Clk(Clk), .MR(MR), .LD(LD), .EN(EN), .MODE(MODE), .DH(DH), .DL(DL),
    .QH(QH), .QL(QL), .BO(BO), .ZERO(ZERO), .BUSY(BUSY)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] l, input logic m);
    DH = h; DL = l; MODE = m; LD = 1'b1;
    step();
    LD = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({QH, QL, BO, ZERO, BUSY} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_init: QH/QL/BO/ZERO/BUSY=%h%h/%b/%b/%b required 00/0/1/0", QH, QL, BO, ZERO, BUSY);
    end
    MR = 1'b0;
    EN = 1'b0;
    do_load(4'd3, 4'd7, 1'b0);
    checks++;
    if ({QH, QL, BUSY} !== {8'h37, 1'b1}) begin
      failures++;
      $display("FAIL load_37: QH/QL/BUSY=%h%h/%b required 37/1", QH, QL, BUSY);
    end
    #2 MR = 1'b1;
    #1;
    checks++;
    if ({QH, QL, BO, ZERO, BUSY} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: QH/QL/BO/ZERO/BUSY=%h%h/%b/%b/%b required 00/0/1/0", QH, QL, BO, ZERO, BUSY);
    end
    MR = 1'b0;
    EN = 1'b1;
    repeat (3) step();
    checks++;
    if ({QH, QL, BO, BUSY} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_hold: QH/QL/BO/BUSY=%h%h/%b/%b required 00/0/0", QH, QL, BO, BUSY);
    end
    EN = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [3:0] eh, el;
    do_load(4'd1, 4'd2, 1'b0);
    checks++;
    if ({QH, QL, BUSY} !== {8'h12, 1'b1}) begin
      failures++;
      $display("FAIL oneshot_load: QH/QL/BUSY=%h%h/%b required 12/1", QH, QL, BUSY);
    end
    EN = 1'b1;
    for (int i = 11; i >= 0; i--) begin
      step();
      eh = 4'(i / 10);
      el = 4'(i % 10);
      checks++;
      if ({QH, QL, BO, BUSY} !== {eh, el, (i == 0), (i != 0)}) begin
        failures++;
        $display("FAIL oneshot_seq: QH/QL/BO/BUSY=%h%h/%b/%b required %h%h/%b/%b",
                 QH, QL, BO, BUSY, eh, el, (i == 0), (i != 0));
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({QH, QL, BO, BUSY, ZERO} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL oneshot_hold: cycle %0d QH/QL/BO/BUSY/ZERO=%h%h/%b/%b/%b required 00/0/0/1",
                 i, QH, QL, BO, BUSY, ZERO);
      end
    end
    EN = 1'b0;
  endtask

  task automatic test_auto_reload();
    int bo_count = 0;
    logic [3:0] exp_l;
    do_load(4'd0, 4'd3, 1'b1);
    EN = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_l = 4'(3 - (k % 4));
      if (BO) bo_count++;
      checks++;
      if ({QH, QL, BO, BUSY} !== {4'd0, exp_l, (exp_l == 4'd0), 1'b1}) begin
        failures++;
        $display("FAIL reload_seq: step %0d QH/QL/BO/BUSY=%h%h/%b/%b required 0%h/%b/1",
                 k, QH, QL, BO, BUSY, exp_l, (exp_l == 4'd0));
      end
    end
    checks++;
    if (bo_count !== 5) begin
      failures++;
      $display("FAIL reload_bo_count: got %0d required 5", bo_count);
    end
    EN = 1'b0;
  endtask

  task automatic test_borrow_clamp();
    do_load(4'hC, 4'h3, 1'b0);
    checks++;
    if ({QH, QL} !== 8'h93) begin
      failures++;
      $display("FAIL clamp_c3: QH/QL=%h%h required 93", QH, QL);
    end
    do_load(4'hF, 4'hA, 1'b0);
    checks++;
    if ({QH, QL} !== 8'h99) begin
      failures++;
      $display("FAIL clamp_fa: QH/QL=%h%h required 99", QH, QL);
    end
    EN = 1'b1;
    repeat (9) step();
    checks++;
    if ({QH, QL} !== 8'h90) begin
      failures++;
      $display("FAIL count_90: QH/QL=%h%h required 90", QH, QL);
    end
    step();
    checks++;
    if ({QH, QL} !== 8'h89) begin
      failures++;
      $display("FAIL borrow_89: QH/QL=%h%h required 89", QH, QL);
    end
    EN = 1'b0;
    do_load(4'd1, 4'd0, 1'b0);
    EN = 1'b1;
    step();
    checks++;
    if ({QH, QL, BO} !== {8'h09, 1'b0}) begin
      failures++;
      $display("FAIL borrow_09: QH/QL/BO=%h%h/%b required 09/0", QH, QL, BO);
    end
    EN = 1'b0;
  endtask

  task automatic test_priority_gaps();
    int bo_count = 0;
    do_load(4'd0, 4'd2, 1'b0);
    EN = 1'b1;
    step();
    checks++;
    if ({QH, QL} !== 8'h01) begin
      failures++;
      $display("FAIL prio_01: QH/QL=%h%h required 01", QH, QL);
    end
    DH = 4'd0; DL = 4'd5; LD = 1'b1;
    step();
    LD = 1'b0;
    checks++;
    if ({QH, QL, BO, BUSY} !== {8'h05, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ld_over_en: QH/QL/BO/BUSY=%h%h/%b/%b required 05/0/1", QH, QL, BO, BUSY);
    end
    EN = 1'b0;
    do_load(4'd0, 4'd2, 1'b0);
    EN = 1'b1; step(); if (BO) bo_count++;
    EN = 1'b0; step(); if (BO) bo_count++;
    checks++;
    if ({QH, QL, BO} !== {8'h01, 1'b0}) begin
      failures++;
      $display("FAIL gap_hold: QH/QL/BO=%h%h/%b required 01/0", QH, QL, BO);
    end
    EN = 1'b1; step(); if (BO) bo_count++;
    checks++;
    if ({QH, QL, BO, BUSY} !== {8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL gap_terminal: QH/QL/BO/BUSY=%h%h/%b/%b required 00/1/0", QH, QL, BO, BUSY);
    end
    EN = 1'b0; step(); if (BO) bo_count++;
    checks++;
    if (BO !== 1'b0) begin
      failures++;
      $display("FAIL bo_width: BO=%b required 0", BO);
    end
    EN = 1'b1; repeat (3) begin step(); if (BO) bo_count++; end
    checks++;
    if (bo_count !== 1) begin
      failures++;
      $display("FAIL gap_bo_count: got %0d required 1", bo_count);
    end
    EN = 1'b0;
  endtask

  task automatic test_zero_preset();
    int bo_count = 0;
    do_load(4'd0, 4'd0, 1'b1);
    EN = 1'b1;
    checks++;
    if ({QH, QL, BO, BUSY, ZERO} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL zero_load: QH/QL/BO/BUSY/ZERO=%h%h/%b/%b/%b required 00/0/0/1", QH, QL, BO, BUSY, ZERO);
    end
    repeat (5) begin step(); if (BO || BUSY) bo_count++; end
    checks++;
    if (bo_count !== 0) begin
      failures++;
      $display("FAIL zero_no_bo: BO/BUSY seen %0d cycles required 0", bo_count);
    end
    EN = 1'b0;
    do_load(4'd0, 4'd1, 1'b1);
    EN = 1'b1;
    step();
    checks++;
    if ({QH, QL, BO, BUSY} !== {8'h00, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL mode1_terminal: QH/QL/BO/BUSY=%h%h/%b/%b required 00/1/1", QH, QL, BO, BUSY);
    end
    MODE = 1'b0;
    step();
    checks++;
    if ({QH, QL, BO, BUSY} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mode_clear_done: QH/QL/BO/BUSY=%h%h/%b/%b required 00/0/0", QH, QL, BO, BUSY);
    end
    EN = 1'b0;
  endtask

  initial begin
    #3;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_borrow_clamp();
    test_priority_gaps();
    test_zero_preset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
